// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
//   Shared definitions for the register-file sequencer: command opcode
//   encoding, FSM state encoding and default data/address widths.
//   Optional feature macro: REGFILE_CTRL_SWAP_EN (enables the SWAP command).
package regfile_ctrl_pkg;

  localparam int DW_DEF = 16;  // register width
  localparam int AW_DEF = 3;   // register index width (8 registers)

  typedef enum logic [1:0] {
    OP_WRITE_IMM = 2'b00,
    OP_MOV       = 2'b01,
    OP_READ      = 2'b10,
    OP_SWAP      = 2'b11
  } op_e;

  // RD_B / WR_B are only ever reached when REGFILE_CTRL_SWAP_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR_A = 3'd3,
    S_WR_B = 3'd4,
    S_RESP = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// regfile_ctrl
//   Command-driven sequencer on the initiator side of an 8x16 register file.
//   Accepts one command at a time (WRITE_IMM, MOV, READ, optional SWAP),
//   runs the register-file read/write cycles and returns a result.
//
//   Handshakes (both cmd_* and rsp_*): a transfer happens on a rising edge
//   where valid and ready are both 1. The producer holds valid and payload
//   stable until the transfer; ready never depends combinationally on valid.
//
//   Ports:
//     clk, reset          rising-edge clock, synchronous active-high reset
//     cmd_valid/ready     command handshake; cmd_op/rd/rs/imm payload
//     rsp_valid/ready     response handshake; rsp_data/rsp_err payload
//     rf_writenum/write/data_in   register file write port
//     rf_readnum/data_out         register file (combinational) read port
//     dbg_state           current FSM state (state_e encoding)
//
//   Optional feature macro: REGFILE_CTRL_SWAP_EN
//     defined   : op 11 swaps rd and rs (RD_A, RD_B, WR_A, WR_B, RESP)
//     undefined : op 11 is rejected with rsp_err=1, rsp_data=0, no write
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [DW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_readnum,
  input  logic [DW-1:0] rf_data_out,
  output logic [2:0]    dbg_state
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] tmpa_q, tmpa_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] writenum_q, writenum_d;
  logic [AW-1:0] readnum_q, readnum_d;
  logic [DW-1:0] data_in_q, data_in_d;
`ifdef REGFILE_CTRL_SWAP_EN
  logic [AW-1:0] rs_q, rs_d;
  logic [DW-1:0] tmpb_q, tmpb_d;
`endif

  // Address/data registers are loaded on the edge that enters the RD/WR
  // state, so they are valid throughout that state and hold afterwards.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    tmpa_d     = tmpa_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    writenum_d = writenum_q;
    readnum_d  = readnum_q;
    data_in_d  = data_in_q;
`ifdef REGFILE_CTRL_SWAP_EN
    rs_d       = rs_q;
    tmpb_d     = tmpb_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          rd_d  = cmd_rd;
          imm_d = cmd_imm;
`ifdef REGFILE_CTRL_SWAP_EN
          rs_d  = cmd_rs;
`endif
          unique case (op_e'(cmd_op))
            OP_WRITE_IMM: begin
              state_d    = S_WR_A;
              writenum_d = cmd_rd;
              data_in_d  = cmd_imm;
            end
            OP_MOV, OP_READ: begin
              state_d   = S_RD_A;
              readnum_d = cmd_rs;
            end
            default: begin  // OP_SWAP
`ifdef REGFILE_CTRL_SWAP_EN
              state_d   = S_RD_A;
              readnum_d = cmd_rs;
`else
              state_d    = S_RESP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
`endif
            end
          endcase
        end
      end
      S_RD_A: begin
        tmpa_d = rf_data_out;
        unique case (op_q)
          OP_MOV: begin
            state_d    = S_WR_A;
            writenum_d = rd_q;
            data_in_d  = rf_data_out;
          end
`ifdef REGFILE_CTRL_SWAP_EN
          OP_SWAP: begin
            state_d   = S_RD_B;
            readnum_d = rd_q;
          end
`endif
          default: begin  // OP_READ
            state_d    = S_RESP;
            rsp_data_d = rf_data_out;
            rsp_err_d  = 1'b0;
          end
        endcase
      end
`ifdef REGFILE_CTRL_SWAP_EN
      S_RD_B: begin
        tmpb_d     = rf_data_out;
        state_d    = S_WR_A;
        writenum_d = rd_q;
        data_in_d  = tmpa_q;
      end
      S_WR_B: begin
        state_d    = S_RESP;
        rsp_data_d = tmpb_q;
        rsp_err_d  = 1'b0;
      end
`endif
      S_WR_A: begin
        unique case (op_q)
`ifdef REGFILE_CTRL_SWAP_EN
          OP_SWAP: begin
            state_d    = S_WR_B;
            writenum_d = rs_q;
            data_in_d  = tmpb_q;
          end
`endif
          OP_MOV: begin
            state_d    = S_RESP;
            rsp_data_d = tmpa_q;
            rsp_err_d  = 1'b0;
          end
          default: begin  // OP_WRITE_IMM
            state_d    = S_RESP;
            rsp_data_d = imm_q;
            rsp_err_d  = 1'b0;
          end
        endcase
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WRITE_IMM;
      rd_q       <= '0;
      imm_q      <= '0;
      tmpa_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      writenum_q <= '0;
      readnum_q  <= '0;
      data_in_q  <= '0;
`ifdef REGFILE_CTRL_SWAP_EN
      rs_q       <= '0;
      tmpb_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      tmpa_q     <= tmpa_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      writenum_q <= writenum_d;
      readnum_q  <= readnum_d;
      data_in_q  <= data_in_d;
`ifdef REGFILE_CTRL_SWAP_EN
      rs_q       <= rs_d;
      tmpb_q     <= tmpb_d;
`endif
    end
  end

  // Gating with reset makes a write abandoned mid-operation never land.
  assign cmd_ready   = (state_q == S_IDLE) && !reset;
  assign rf_write    = ((state_q == S_WR_A) || (state_q == S_WR_B)) && !reset;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rf_writenum = writenum_q;
  assign rf_readnum  = readnum_q;
  assign rf_data_in  = data_in_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl
//   Bench for regfile_ctrl with a behavioural 8x16 register file attached.
//   Honours REGFILE_CTRL_SWAP_EN the same way as the design.
module tb_regfile_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0;
  logic [AW-1:0] cmd_rs = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] rf_writenum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] rf_readnum;
  logic [DW-1:0] rf_data_out;
  logic [2:0]    dbg_state;

  regfile_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .dbg_state(dbg_state)
  );

  // ---------------- register file model ----------------
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  int            wr_count = 0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_writenum] <= rf_data_in;
      wr_count            <= wr_count + 1;
      last_wa             <= rf_writenum;
      last_wd             <= rf_data_in;
    end
  end
  assign rf_data_out = rf_mem[rf_readnum];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];
  logic [DW-1:0] exp_mem [8];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one command; updates the expected register image.
  task automatic predict(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [DW-1:0] imm, output logic [DW-1:0] data,
                         output logic err, output int lat, output int nwr);
    logic [DW-1:0] a, b;
    err = 1'b0;
    case (op)
      2'b00: begin exp_mem[rd] = imm; data = imm; lat = 2; nwr = 1; end
      2'b01: begin data = exp_mem[rs]; exp_mem[rd] = data; lat = 3; nwr = 1; end
      2'b10: begin data = exp_mem[rs]; lat = 2; nwr = 0; end
      default: begin
`ifdef REGFILE_CTRL_SWAP_EN
        a = exp_mem[rs]; b = exp_mem[rd];
        exp_mem[rd] = a; exp_mem[rs] = b;
        data = b; lat = 5; nwr = 2;
`else
        a = '0; b = '0;
        data = a | b; err = 1'b1; lat = 1; nwr = 0;
`endif
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Pushes expectation on drive,
  // pops and compares when the response appears.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [DW-1:0] imm, input logic [DW-1:0] exp_data,
                         input logic exp_err, input int exp_lat, input int exp_wr,
                         input int hold);
    int lat;
    int wr0;
    logic [DW-1:0] d;
    logic e;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    exp_q.push_back(exp_data);
    exp_err_q.push_back(exp_err);
    wr0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      chk("cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
      return;
    end
    chk("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp_q[0]);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_write", rf_write, 0);
      @(negedge clk);
    end
    d = exp_q.pop_front();
    e = exp_err_q.pop_front();
    chk("rsp_data", rsp_data, d);
    chk("rsp_err", rsp_err, e);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("write_count", wr_count - wr0, exp_wr);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_lat;
    int            exp_wr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [DW-1:0] pd;
    logic pe;
    int pl, pw, snap;
    logic [DW-1:0] keep;
    logic [1:0] rop;
    logic [AW-1:0] rrd, rrs;
    logic [DW-1:0] rimm;

    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    vecs[0]  = '{2'b00, 3'd3, 3'd0, 16'd42,   16'd42,   1'b0, 2, 1};
    vecs[1]  = '{2'b10, 3'd0, 3'd3, 16'h0,    16'd42,   1'b0, 2, 0};
    vecs[2]  = '{2'b00, 3'd1, 3'd0, 16'h1234, 16'h1234, 1'b0, 2, 1};
    vecs[3]  = '{2'b01, 3'd5, 3'd1, 16'h0,    16'h1234, 1'b0, 3, 1};
    vecs[4]  = '{2'b10, 3'd0, 3'd5, 16'h0,    16'h1234, 1'b0, 2, 0};
    vecs[5]  = '{2'b10, 3'd0, 3'd1, 16'h0,    16'h1234, 1'b0, 2, 0};
    vecs[6]  = '{2'b00, 3'd2, 3'd0, 16'h00AA, 16'h00AA, 1'b0, 2, 1};
    vecs[7]  = '{2'b00, 3'd6, 3'd0, 16'h5500, 16'h5500, 1'b0, 2, 1};
`ifdef REGFILE_CTRL_SWAP_EN
    vecs[8]  = '{2'b11, 3'd6, 3'd2, 16'h0,    16'h5500, 1'b0, 5, 2};
    vecs[9]  = '{2'b10, 3'd0, 3'd6, 16'h0,    16'h00AA, 1'b0, 2, 0};
    vecs[10] = '{2'b10, 3'd0, 3'd2, 16'h0,    16'h5500, 1'b0, 2, 0};
`else
    vecs[8]  = '{2'b11, 3'd6, 3'd2, 16'h0,    16'h0000, 1'b1, 1, 0};
    vecs[9]  = '{2'b10, 3'd0, 3'd6, 16'h0,    16'h5500, 1'b0, 2, 0};
    vecs[10] = '{2'b10, 3'd0, 3'd2, 16'h0,    16'h00AA, 1'b0, 2, 0};
`endif
    vecs[11] = '{2'b00, 3'd7, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 2, 1};
    vecs[12] = '{2'b01, 3'd7, 3'd7, 16'h0,    16'hBEEF, 1'b0, 3, 1};
    vecs[13] = '{2'b10, 3'd0, 3'd7, 16'h0,    16'hBEEF, 1'b0, 2, 0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_writenum", rf_writenum, 0);
    chk("rst_readnum", rf_readnum, 0);
    chk("rst_data_in", rf_data_in, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", cmd_ready, 1);
    @(negedge clk);

    // table
    for (int i = 0; i < 14; i++) begin
      predict(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, pd, pe, pl, pw);
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm,
              vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wr, 0);
      if (vecs[i].op == 2'b00) begin
        chk("wr_addr", last_wa, vecs[i].rd);
        chk("wr_data", last_wd, vecs[i].imm);
      end
    end
    chk("mov_src_unchanged", rf_mem[1], 16'h1234);
    chk("mov_dst", rf_mem[5], 16'h1234);
    chk("mov_self", rf_mem[7], 16'hBEEF);

    // response held off for 4 cycles
    predict(2'b10, 3'd0, 3'd3, 16'h0, pd, pe, pl, pw);
    run_cmd(2'b10, 3'd0, 3'd3, 16'h0, 16'd42, 1'b0, 2, 0, 4);

    // reset during WR_A of WRITE_IMM: write must be suppressed
    snap = wr_count;
    keep = rf_mem[4];
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd4; cmd_imm = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wra_write_high", rf_write, 1);
    reset = 1'b1;
    #1;
    chk("wra_reset_gate", rf_write, 0);
    @(posedge clk);
    @(negedge clk);
    chk("wra_rst_valid", rsp_valid, 0);
    chk("wra_rst_writenum", rf_writenum, 0);
    chk("wra_rst_data_in", rf_data_in, 0);
    chk("wra_rst_state", dbg_state, 0);
    chk("wra_rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("wra_release_ready", cmd_ready, 1);
    chk("wra_no_write", wr_count - snap, 0);
    chk("wra_reg_kept", rf_mem[4], keep);
    @(negedge clk);

    // reset during RD_A of MOV
    snap = wr_count;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 3'd4; cmd_rs = 3'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mov_rda_readnum", rf_readnum, 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mov_rst_valid", rsp_valid, 0);
    chk("mov_rst_readnum", rf_readnum, 0);
    chk("mov_rst_rsp_data", rsp_data, 0);
    chk("mov_rst_write", rf_write, 0);
    reset = 1'b0;
    #1;
    chk("mov_release_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("mov_no_write", wr_count - snap, 0);
    chk("mov_reg_kept", rf_mem[4], keep);

    // random commands against the reference model
    for (int i = 0; i < 24; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rrd  = 3'($urandom_range(0, 7));
      rrs  = 3'($urandom_range(0, 7));
      rimm = 16'($urandom_range(0, 65535));
      predict(rop, rrd, rrs, rimm, pd, pe, pl, pw);
      run_cmd(rop, rrd, rrs, rimm, pd, pe, pl, pw, int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 8; i++) chk("final_reg", rf_mem[i], exp_mem[i]);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
